// File: rtl/dwc_spe_result_packer.sv
// rtl/dwc_spe_result_packer.sv - SPE product requantiser, beat packer and show-ahead output FIFO
module dwc_spe_result_packer #(
  parameter int WORD_SIZE      = 16,
  parameter int HALF_SIZE      = WORD_SIZE / 2,
  parameter int TILE_NUM       = 2,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int WORDS_PER_BEAT = OUT_DATA_WIDTH / WORD_SIZE,
  parameter int FIFO_DEPTH     = 8,
  parameter int AFULL_MARGIN   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        set_isize,
  input  logic [5:0]                  quant_next_layer,
  input  logic                        spe_valid,
  input  logic [WORD_SIZE-1:0]        spe_product,
  input  logic                        spe_last,
  output logic                        spe_afull,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [OUT_DATA_WIDTH-1:0]   m_data,
  output logic [OUT_DATA_WIDTH/8-1:0] m_strb,
  output logic                        m_last,
  output logic                        overflow,
  output logic [15:0]                 beat_count
);

  localparam int STRB_W     = OUT_DATA_WIDTH / 8;
  localparam int BYTES_WORD = WORD_SIZE / 8;
  localparam int SLOT_W     = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int ADDR_W     = $clog2(FIFO_DEPTH);
  localparam int PTR_W      = ADDR_W + 1;
  localparam int ENTRY_W    = 1 + STRB_W + OUT_DATA_WIDTH;
  localparam int EXT_W      = WORD_SIZE + 9;
  localparam int LANE_EXT_W = HALF_SIZE + 9;

  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(WORDS_PER_BEAT - 1);
  localparam logic [PTR_W-1:0]  FULL_LEVEL  = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  AFULL_LEVEL = PTR_W'(FIFO_DEPTH - AFULL_MARGIN);

  // Shift in the widened domain, then saturate if the bits above the result's sign disagree.
  function automatic logic [WORD_SIZE-1:0] requant_word(input logic [WORD_SIZE-1:0] w,
                                                         input logic [5:0] q);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] sh;
    logic [5:0]              mag;
    begin
      ext = {{(EXT_W-WORD_SIZE){w[WORD_SIZE-1]}}, w};
      mag = ~q + 6'd1;
      sh  = q[5] ? (ext <<< mag) : (ext >>> q);
      if ((&sh[EXT_W-1:WORD_SIZE-1]) || !(|sh[EXT_W-1:WORD_SIZE-1]))
        requant_word = sh[WORD_SIZE-1:0];
      else if (sh[EXT_W-1])
        requant_word = {1'b1, {(WORD_SIZE-1){1'b0}}};
      else
        requant_word = {1'b0, {(WORD_SIZE-1){1'b1}}};
    end
  endfunction

  function automatic logic [HALF_SIZE-1:0] requant_lane(input logic [HALF_SIZE-1:0] w,
                                                         input logic [5:0] q);
    logic signed [LANE_EXT_W-1:0] ext;
    logic signed [LANE_EXT_W-1:0] sh;
    logic [5:0]                   mag;
    begin
      ext = {{(LANE_EXT_W-HALF_SIZE){w[HALF_SIZE-1]}}, w};
      mag = ~q + 6'd1;
      sh  = q[5] ? (ext <<< mag) : (ext >>> q);
      if ((&sh[LANE_EXT_W-1:HALF_SIZE-1]) || !(|sh[LANE_EXT_W-1:HALF_SIZE-1]))
        requant_lane = sh[HALF_SIZE-1:0];
      else if (sh[LANE_EXT_W-1])
        requant_lane = {1'b1, {(HALF_SIZE-1){1'b0}}};
      else
        requant_lane = {1'b0, {(HALF_SIZE-1){1'b1}}};
    end
  endfunction

  logic [WORD_SIZE-1:0]      rq_next;
  logic                      rq_valid;
  logic [WORD_SIZE-1:0]      rq_data;
  logic                      rq_last;
  logic [SLOT_W-1:0]         slot;
  logic [OUT_DATA_WIDTH-1:0] pack_data;
  logic [STRB_W-1:0]         pack_strb;
  logic [OUT_DATA_WIDTH-1:0] beat_data;
  logic [STRB_W-1:0]         beat_strb;
  logic                      beat_close;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          count;
  logic                      full;
  logic                      pop;
  logic                      push_ok;
  logic                      push_drop;
  logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]        head;

  always_comb begin
    rq_next = '0;
    if (set_isize) begin
      rq_next = requant_word(spe_product, quant_next_layer);
    end else begin
      for (int i = 0; i < TILE_NUM; i++)
        rq_next[i*HALF_SIZE +: HALF_SIZE] =
          requant_lane(spe_product[i*HALF_SIZE +: HALF_SIZE], quant_next_layer);
    end
  end

  // The beat as it would look with the current requantised word dropped into its slot.
  always_comb begin
    beat_data = pack_data;
    beat_strb = pack_strb;
    beat_data[int'(slot)*WORD_SIZE +: WORD_SIZE]   = rq_data;
    beat_strb[int'(slot)*BYTES_WORD +: BYTES_WORD] = '1;
  end

  assign beat_close = rq_valid && ((slot == LAST_SLOT) || rq_last);
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_LEVEL);
  assign m_valid    = (count != '0);
  assign pop        = m_valid && m_ready;
  assign push_ok    = beat_close && (!full || pop);
  assign push_drop  = beat_close && full && !pop;
  assign spe_afull  = (count >= AFULL_LEVEL);

  assign head   = mem[rd_ptr[ADDR_W-1:0]];
  assign m_data = m_valid ? head[OUT_DATA_WIDTH-1:0] : '0;
  assign m_strb = m_valid ? head[OUT_DATA_WIDTH +: STRB_W] : '0;
  assign m_last = m_valid && head[ENTRY_W-1];

  always_ff @(posedge clk) begin
    if (push_ok && !clear)
      mem[wr_ptr[ADDR_W-1:0]] <= {rq_last, beat_strb, beat_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_valid   <= 1'b0;
      rq_data    <= '0;
      rq_last    <= 1'b0;
      slot       <= '0;
      pack_data  <= '0;
      pack_strb  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      beat_count <= '0;
    end else if (clear) begin
      rq_valid   <= 1'b0;
      rq_data    <= '0;
      rq_last    <= 1'b0;
      slot       <= '0;
      pack_data  <= '0;
      pack_strb  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      beat_count <= '0;
    end else begin
      rq_valid <= spe_valid;
      if (spe_valid) begin
        rq_data <= rq_next;
        rq_last <= spe_last;
      end
      if (rq_valid) begin
        if (beat_close) begin
          slot      <= '0;
          pack_data <= '0;
          pack_strb <= '0;
        end else begin
          slot      <= slot + 1'b1;
          pack_data <= beat_data;
          pack_strb <= beat_strb;
        end
      end
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_drop)
        overflow <= 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        beat_count <= beat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dwc_spe_result_packer.sv
// tb/tb_dwc_spe_result_packer.sv - directed vector bench for dwc_spe_result_packer
module tb_dwc_spe_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        set_isize;
  logic [5:0]  quant;
  logic        spe_valid;
  logic [15:0] spe_product;
  logic        spe_last;
  logic        spe_afull;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic        m_last;
  logic        overflow;
  logic [15:0] beat_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_beats;

  always #5 clk = ~clk;

  dwc_spe_result_packer dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .set_isize        (set_isize),
    .quant_next_layer (quant),
    .spe_valid        (spe_valid),
    .spe_product      (spe_product),
    .spe_last         (spe_last),
    .spe_afull        (spe_afull),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_strb           (m_strb),
    .m_last           (m_last),
    .overflow         (overflow),
    .beat_count       (beat_count)
  );

  typedef struct {
    logic        isize;
    logic [5:0]  q;
    logic [15:0] w;
    logic [15:0] exp;
  } rq_vec_t;

  rq_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic last);
    spe_valid   = 1'b1;
    spe_product = w;
    spe_last    = last;
    tick();
    spe_valid = 1'b0;
    spe_last  = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] base, input logic last);
    for (int j = 0; j < 4; j++)
      send_word(base + 16'(j), last && (j == 3));
  endtask

  function automatic logic [63:0] beat_of(input logic [15:0] base);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 4; j++)
      b[j*16 +: 16] = base + 16'(j);
    return b;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 6'd2,      16'h0100, 16'h0040};
    vecs[1]  = '{1'b1, 6'b111100, 16'h1000, 16'h7FFF};
    vecs[2]  = '{1'b1, 6'b111111, 16'h8001, 16'h8000};
    vecs[3]  = '{1'b1, 6'd0,      16'h1234, 16'h1234};
    vecs[4]  = '{1'b0, 6'd1,      16'h80F0, 16'hC0F8};
    vecs[5]  = '{1'b0, 6'b111110, 16'h4020, 16'h7F7F};
    vecs[6]  = '{1'b1, 6'd1,      16'hFFFF, 16'hFFFF};
    vecs[7]  = '{1'b0, 6'd0,      16'hA55A, 16'hA55A};
    vecs[8]  = '{1'b1, 6'b111111, 16'h3FFF, 16'h7FFE};
    vecs[9]  = '{1'b1, 6'b111111, 16'h4000, 16'h7FFF};
    vecs[10] = '{1'b0, 6'b111111, 16'hC0BF, 16'h8080};
    vecs[11] = '{1'b1, 6'd31,     16'h8000, 16'hFFFF};

    rst = 1'b1; clear = 1'b0; set_isize = 1'b1; quant = '0;
    spe_valid = 1'b0; spe_product = '0; spe_last = 1'b0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_strb", m_strb, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_afull", spe_afull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_beat_count", beat_count, 0);
    rst = 1'b0;
    tick();

    // Full beat, quant=2, latency of two cycles after the closing word
    m_ready = 1'b1; set_isize = 1'b1; quant = 6'd2;
    send_word(16'h0100, 1'b0);
    send_word(16'h0200, 1'b0);
    send_word(16'hFF00, 1'b0);
    send_word(16'h0004, 1'b1);
    chk("lat_t1_valid", m_valid, 0);
    tick();
    chk("lat_t2_valid", m_valid, 1);
    chk("full_data", m_data, 64'h0001_FFC0_0080_0040);
    chk("full_strb", m_strb, 8'hFF);
    chk("full_last", m_last, 1);
    tick();
    chk("pop_empty", m_valid, 0);
    chk("bc_first", beat_count, 1);
    exp_beats = 1;

    for (int i = 0; i < 12; i++) begin
      set_isize = vecs[i].isize;
      quant     = vecs[i].q;
      send_word(vecs[i].w, 1'b1);
      tick();
      chk($sformatf("vec%0d_valid", i), m_valid, 1);
      chk($sformatf("vec%0d_data", i), m_data, {48'h0, vecs[i].exp});
      chk($sformatf("vec%0d_strb", i), m_strb, 8'h03);
      chk($sformatf("vec%0d_last", i), m_last, 1);
      tick();
      exp_beats++;
    end
    chk("bc_vectors", beat_count, 16'(exp_beats));

    // Partial beat, then a full beat without last must start from slot 0
    set_isize = 1'b1; quant = 6'd0;
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b1);
    tick();
    chk("part_data", m_data, 64'h0000_0000_2222_1111);
    chk("part_strb", m_strb, 8'h0F);
    chk("part_last", m_last, 1);
    tick();
    send_beat(16'h0A00, 1'b0);
    tick();
    chk("next_data", m_data, beat_of(16'h0A00));
    chk("next_strb", m_strb, 8'hFF);
    chk("next_last", m_last, 0);
    tick();

    // Backpressure: nine beats into an eight-entry FIFO
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_bc", beat_count, 0);
    m_ready = 1'b0;
    for (int b = 0; b < 9; b++) begin
      send_beat(16'h1000 + 16'(b*16), 1'b0);
      tick(); tick();
      chk($sformatf("bp%0d_afull", b), spe_afull, (b + 1) >= 5);
      chk($sformatf("bp%0d_ovf", b), overflow, b == 8);
      chk($sformatf("bp%0d_head", b), m_data, beat_of(16'h1000));
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), m_valid, 1);
      chk($sformatf("drain%0d_data", i), m_data, beat_of(16'h1000 + 16'(i*16)));
      tick();
    end
    chk("drain_empty", m_valid, 0);
    chk("drain_bc", beat_count, 8);
    chk("drain_ovf_sticky", overflow, 1);

    // Asynchronous reset with two words already packed
    send_word(16'h5555, 1'b0);
    send_word(16'h6666, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_ovf", overflow, 0);
    chk("arst_bc", beat_count, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_afull", spe_afull, 0);
    tick();
    rst = 1'b0;
    tick();
    send_beat(16'h2000, 1'b1);
    tick();
    chk("arst_beat", m_data, beat_of(16'h2000));
    chk("arst_strb", m_strb, 8'hFF);
    chk("arst_last", m_last, 1);
    tick();
    chk("arst_bc_after", beat_count, 1);

    // Synchronous clear with two words in flight and overflow set
    m_ready = 1'b0;
    for (int b = 0; b < 9; b++)
      send_beat(16'h3000 + 16'(b*16), 1'b0);
    tick(); tick();
    chk("refill_ovf", overflow, 1);
    chk("refill_afull", spe_afull, 1);
    send_word(16'h7777, 1'b0);
    send_word(16'h8888, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_valid", m_valid, 0);
    chk("clr_bc2", beat_count, 0);
    chk("clr_afull", spe_afull, 0);
    m_ready = 1'b1;
    send_beat(16'h4000, 1'b1);
    tick();
    chk("clr_beat", m_data, beat_of(16'h4000));
    chk("clr_last", m_last, 1);
    tick();
    chk("clr_bc_after", beat_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
